// File: rtl/fsm1_seq_gen.sv
// rtl/fsm1_seq_gen.sv - serial pattern generator, MSB-first with repeat count and zero-filled gaps
module fsm1_seq_gen #(
    parameter int W   = 8,
    parameter int CW  = 4,
    parameter int GAP = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic [W-1:0]  pattern,
    input  logic [3:0]    len,
    input  logic [CW-1:0] reps,
    output logic          ready,
    output logic          x,
    output logic          xv,
    output logic          done
);

    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAPW = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    pat_q, pat_d;
    logic [3:0]      len_q, len_d;
    logic [3:0]      idx_q, idx_d;
    logic [CW-1:0]   rep_q, rep_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            ready_q, ready_d;
    logic            x_q, x_d;
    logic            xv_q, xv_d;
    logic            done_q, done_d;

    logic [3:0]      len_eff;
    logic [CW-1:0]   reps_eff;
    logic [15:0]     pat_ext;

    // Outputs are computed from the next state so they are registered yet
    // line up with the cycle that state represents.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        idx_d    = idx_q;
        rep_d    = rep_q;
        gap_d    = gap_q;

        len_eff  = ((len == 4'd0) || (len > 4'(W))) ? 4'(W) : len;
        reps_eff = (reps == '0) ? CW'(1) : reps;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    len_d   = len_eff;
                    idx_d   = len_eff - 4'd1;
                    rep_d   = reps_eff;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (idx_q == 4'd0) begin
                    if (rep_q > CW'(1)) begin
                        rep_d = rep_q - CW'(1);
                        if (GAP > 0) begin
                            gap_d   = GW'(GAP - 1);
                            state_d = GAPW;
                        end else begin
                            idx_d = len_q - 4'd1;
                        end
                    end else begin
                        if (rep_q != '0) begin
                            rep_d = rep_q - CW'(1);
                        end
                        state_d = DONE;
                    end
                end else begin
                    idx_d = idx_q - 4'd1;
                end
            end
            GAPW: begin
                if (gap_q == '0) begin
                    idx_d   = len_q - 4'd1;
                    state_d = SEND;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pat_ext = {{(16 - W){1'b0}}, pat_d};
        ready_d = (state_d == IDLE);
        xv_d    = (state_d == SEND);
        x_d     = xv_d & pat_ext[idx_d];
        done_d  = (state_d == DONE);
    end

    // State, counters and registered outputs; clr clears everything at once.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            ready_q <= 1'b1;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign x     = x_q;
    assign xv    = xv_q;
    assign done  = done_q;

endmodule

// File: tb/tb_fsm1_seq_gen.sv
// tb/tb_fsm1_seq_gen.sv - directed-vector bench for fsm1_seq_gen
module tb_fsm1_seq_gen;

    logic       clk = 1'b0;
    logic       clr;
    logic       start0, start1;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] reps;
    logic       ready0, x0, xv0, done0;
    logic       ready1, x1, xv1, done1;

    int n_checks = 0;
    int n_errors = 0;
    int cur_cyc  = 0;

    logic [2:0] hist    = 3'b000;
    int         det_cnt = 0;

    fsm1_seq_gen #(.W(8), .CW(4), .GAP(2)) dut_gap2 (
        .clk(clk), .clr(clr), .start(start0), .pattern(pattern), .len(len), .reps(reps),
        .ready(ready0), .x(x0), .xv(xv0), .done(done0)
    );

    fsm1_seq_gen #(.W(8), .CW(4), .GAP(0)) dut_gap0 (
        .clk(clk), .clr(clr), .start(start1), .pattern(pattern), .len(len), .reps(reps),
        .ready(ready1), .x(x1), .xv(xv1), .done(done1)
    );

    always #5 clk = ~clk;

    // Downstream 101 detector watching the GAP=2 generator
    always @(negedge clk) begin
        hist <= {hist[1:0], x0};
        if ({hist[1:0], x0} == 3'b101) det_cnt <= det_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cur_cyc, got, exp);
        end
    endtask

    task automatic kick(input bit sel, input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        @(negedge clk);
        pattern = p;
        len     = l;
        reps    = r;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
    endtask

    // Walks cycles 1..done_cyc+1 after acceptance; bit c-1 of the vectors is cycle c.
    task automatic expect_run(input bit sel, input int done_cyc, input logic [31:0] ex_xv,
                              input logic [31:0] ex_x, input int poke_cyc);
        logic vx, vxv, vd, vr;
        for (int c = 1; c <= done_cyc + 1; c++) begin
            @(negedge clk);
            cur_cyc = c;
            if (c == 1) begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            vx  = sel ? x1     : x0;
            vxv = sel ? xv1    : xv0;
            vd  = sel ? done1  : done0;
            vr  = sel ? ready1 : ready0;
            check("xv",    {31'd0, vxv}, {31'd0, ex_xv[c-1]});
            check("x",     {31'd0, vx},  {31'd0, ex_x[c-1]});
            check("done",  {31'd0, vd},  {31'd0, (c == done_cyc)});
            check("ready", {31'd0, vr},  {31'd0, (c == done_cyc + 1)});
            if (c == poke_cyc) begin
                start0  = 1'b1;
                pattern = 8'h3C;
                len     = 4'd3;
            end
            if (poke_cyc != 0 && c == poke_cyc + 1) start0 = 1'b0;
        end
    endtask

    initial begin
        int d0;
        clr     = 1'b1;
        start0  = 1'b0;
        start1  = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;

        #12;
        check("rst_ready", {31'd0, ready0}, 32'd1);
        check("rst_x",     {31'd0, x0},     32'd0);
        check("rst_xv",    {31'd0, xv0},    32'd0);
        check("rst_done",  {31'd0, done0},  32'd0);
        check("rst_ready1", {31'd0, ready1}, 32'd1);
        @(negedge clk);
        clr = 1'b0;

        // Basic 101
        d0 = det_cnt;
        kick(1'b0, 8'h05, 4'd3, 4'd1);
        expect_run(1'b0, 4, 32'h7, 32'h5, 0);
        check("det101", det_cnt - d0, 32'd1);

        // Three repeats with 2-cycle gaps
        kick(1'b0, 8'h05, 4'd3, 4'd3);
        expect_run(1'b0, 14, 32'h1CE7, 32'h14A5, 0);

        // len=0 and len>W clamp to W
        kick(1'b0, 8'hA5, 4'd0, 4'd1);
        expect_run(1'b0, 9, 32'hFF, 32'hA5, 0);
        kick(1'b0, 8'hA5, 4'd12, 4'd1);
        expect_run(1'b0, 9, 32'hFF, 32'hA5, 0);

        // reps=0 gives a single repetition
        kick(1'b0, 8'h05, 4'd3, 4'd0);
        expect_run(1'b0, 4, 32'h7, 32'h5, 0);

        // Busy protection: start and pattern change in cycle 2
        kick(1'b0, 8'hA5, 4'd8, 4'd1);
        expect_run(1'b0, 9, 32'hFF, 32'hA5, 2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cur_cyc = 11 + k;
            check("busy_xv",    {31'd0, xv0},    32'd0);
            check("busy_ready", {31'd0, ready0}, 32'd1);
        end

        // Asynchronous clear mid-transfer, then immediate restart
        kick(1'b0, 8'hC3, 4'd8, 4'd1);
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        cur_cyc = 2;
        check("pre_clr_x", {31'd0, x0}, 32'd1);
        #1 clr = 1'b1;
        #1;
        check("clr_x",     {31'd0, x0},     32'd0);
        check("clr_xv",    {31'd0, xv0},    32'd0);
        check("clr_done",  {31'd0, done0},  32'd0);
        check("clr_ready", {31'd0, ready0}, 32'd1);
        #1 clr = 1'b0;
        start0 = 1'b1;
        expect_run(1'b0, 9, 32'hFF, 32'hC3, 0);

        // GAP=0 back-to-back repetitions
        kick(1'b1, 8'h02, 4'd2, 4'd2);
        expect_run(1'b1, 5, 32'hF, 32'h5, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
